alu_z_unit: RTL

Execution stage directly downstream of the Y operand register in the 8-bit RISC SPM datapath. It takes operand A from the processor bus and operand B from the Y register output, and executes one of eight operations. It registers the result, a zero flag (Z) and a carry/overflow flag (C) for the controller. Single-cycle operations complete in one cycle. MUL is an iterative shift-add taking WIDTH cycles, sequenced by a start/busy/done handshake with the control unit.

---
 rtl/alu_z_unit_if.sv | 25 ++
 rtl/alu_z_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_z_unit_if.sv
// Handshake and operand/result bundle between the RISC SPM control unit and the ALU stage.
// The master drives operands and start; the slave (ALU) returns status, result and flags.
interface alu_z_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] alu_a_in;
  logic [WIDTH-1:0] alu_b_in;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_busy;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_z;
  logic             alu_c;

  modport master (
    output alu_a_in, alu_b_in, alu_op, alu_start,
    input  alu_busy, alu_done, alu_result, alu_z, alu_c
  );

  modport slave (
    input  alu_a_in, alu_b_in, alu_op, alu_start,
    output alu_busy, alu_done, alu_result, alu_z, alu_c
  );
endinterface

// File: rtl/alu_z_unit.sv
// Execution stage behind the Y register: single-cycle ALU ops plus an iterative shift-add
// multiply, with registered result, zero and carry flags and a start/busy/done handshake.
module alu_z_unit #(
  parameter int unsigned WIDTH = 8
) (
  input logic        reg_y_clk,
  input logic        reg_y_rst,
  alu_z_unit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpNot   = 3'b011;
  localparam logic [2:0] OpMul   = 3'b100;
  localparam logic [2:0] OpShl   = 3'b101;
  localparam logic [2:0] OpShr   = 3'b110;
  localparam logic [2:0] OpPassb = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d;
  logic               c_q, c_d;

  logic [WIDTH-1:0]   exec_res;
  logic               exec_c;
  logic [WIDTH:0]     ext_sum;
  logic [WIDTH:0]     ext_diff;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;

  // Single-cycle datapath; the extra MSB of the extended add/subtract is carry/borrow.
  always_comb begin
    ext_sum  = {1'b0, a_q} + {1'b0, b_q};
    ext_diff = {1'b0, a_q} - {1'b0, b_q};
    exec_res = '0;
    exec_c   = 1'b0;
    unique case (op_q)
      OpAdd:   begin exec_res = ext_sum[WIDTH-1:0];  exec_c = ext_sum[WIDTH];  end
      OpSub:   begin exec_res = ext_diff[WIDTH-1:0]; exec_c = ext_diff[WIDTH]; end
      OpAnd:   exec_res = a_q & b_q;
      OpNot:   exec_res = ~a_q;
      OpMul:   exec_res = '0;
      OpShl:   begin exec_res = {a_q[WIDTH-2:0], 1'b0}; exec_c = a_q[WIDTH-1]; end
      OpShr:   begin exec_res = {1'b0, a_q[WIDTH-1:1]}; exec_c = a_q[0];       end
      OpPassb: exec_res = b_q;
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    partial = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    unique case (state_q)
      StIdle: begin
        if (bus.alu_start) begin
          a_d     = bus.alu_a_in;
          b_d     = bus.alu_b_in;
          op_d    = bus.alu_op;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = (bus.alu_op == OpMul) ? StMul : StExec;
        end
      end
      StExec: begin
        result_d = exec_res;
        z_d      = (exec_res == '0);
        c_d      = exec_c;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      StMul: begin
        acc_d = acc_sum;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d = acc_sum[WIDTH-1:0];
          z_d      = (acc_sum[WIDTH-1:0] == '0);
          c_d      = |acc_sum[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge reg_y_clk or posedge reg_y_rst) begin
    if (reg_y_rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  assign bus.alu_busy   = busy_q;
  assign bus.alu_done   = done_q;
  assign bus.alu_result = result_q;
  assign bus.alu_z      = z_q;
  assign bus.alu_c      = c_q;

endmodule
